// File: rtl/cdc_rd_drain.sv
// rtl/cdc_rd_drain.sv - read-side drain: pops the CDC FIFO eagerly into a local buffer
// Downstream backpressure never stalls the CDC pop while the local buffer has room.
module cdc_rd_drain #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int FLOPS_NOT_MEM = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cg,
  input  logic                       i_cdcEmpty,
  output logic                       o_cdcPop,
  input  logic [WIDTH-1:0]           i_cdcData,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_nEntries
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_take;
  logic             w_give;
  logic [WIDTH-1:0] w_rd_data;

  assign o_valid    = (r_count != '0);
  assign o_nEntries = r_count;
  assign w_give     = i_cg && o_valid && i_ready;
  // Popping while full is safe only because the same edge drains a word.
  assign w_take     = i_cg && !i_rst && !i_cdcEmpty &&
                      ((r_count < FULL_CNT) || (o_valid && i_ready));
  assign o_cdcPop   = w_take;
  assign o_data     = w_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_take) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_give) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_take, w_give})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (FLOPS_NOT_MEM != 0) begin : g_flops
      logic [DEPTH-1:0][WIDTH-1:0] r_regs;

      always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_take && (r_wr_ptr == PW'(i))) r_regs[i] <= i_cdcData;
        end
      end

      always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd_ptr == PW'(i)) w_rd_data = r_regs[i];
        end
      end
    end else begin : g_mem
      logic [WIDTH-1:0] r_mem [DEPTH];

      always_ff @(posedge i_clk) begin
        if (w_take) r_mem[r_wr_ptr] <= i_cdcData;
      end

      assign w_rd_data = r_mem[r_rd_ptr];
    end
  endgenerate

endmodule
